// File: rtl/spwm_pkg.sv
// Shared definitions for the sine-PWM half-bridge modulator.
//   leg_state_t : leg FSM encoding (DEAD / UPPER / LOWER)
//   CNT_W       : carrier counter width
//   DT_W        : dead-time timer width
//   PROD_W      : width of the signed comparator products
package spwm_pkg;

  localparam int CNT_W  = 12;
  localparam int DT_W   = 8;
  localparam int PROD_W = 34;

  typedef enum logic [1:0] {
    ST_DEAD  = 2'd0,
    ST_UPPER = 2'd1,
    ST_LOWER = 2'd2
  } leg_state_t;

endpackage

// File: rtl/spwm_deadtime.sv
// Leg FSM with dead-time insertion for one complementary half-bridge leg.
// Ports:
//   clk_20M, reset_n : clock, synchronous active-low reset
//   desire           : requested switch (1 = upper on, 0 = lower on)
//   blank            : forces DEAD with the timer held at 0
//   gate_hi, gate_lo : registered gate drives, never both 1
//   state            : current FSM state (debug visibility)
// Every switch-over passes through DEAD for exactly DEADTIME cycles. The
// gates are registered from the next state, so they line up with `state`.
module spwm_deadtime
  import spwm_pkg::*;
#(
  parameter int DEADTIME = 40
) (
  input  logic       clk_20M,
  input  logic       reset_n,
  input  logic       desire,
  input  logic       blank,
  output logic       gate_hi,
  output logic       gate_lo,
  output leg_state_t state
);

  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);

  leg_state_t      state_q;
  leg_state_t      state_next;
  logic [DT_W-1:0] timer_q;
  logic [DT_W-1:0] timer_next;

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      state_q <= ST_DEAD;
      timer_q <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      state_q <= state_next;
      timer_q <= timer_next;
      gate_hi <= (state_next == ST_UPPER);
      gate_lo <= (state_next == ST_LOWER);
    end
  end

  // Timer only runs in DEAD; desire changes inside DEAD do not restart it,
  // and the exit direction is taken from desire at expiry.
  always_comb begin
    state_next = state_q;
    timer_next = '0;
    if (blank) begin
      state_next = ST_DEAD;
      timer_next = '0;
    end else begin
      case (state_q)
        ST_DEAD: begin
          if (timer_q == DT_LAST) begin
            state_next = desire ? ST_UPPER : ST_LOWER;
          end else begin
            timer_next = timer_q + 1'b1;
          end
        end
        ST_UPPER: if (!desire) state_next = ST_DEAD;
        ST_LOWER: if (desire)  state_next = ST_DEAD;
        default:  state_next = ST_DEAD;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/spwm_modulator.sv
// Sine-PWM modulator for one half-bridge leg.
// Compares the sampled reference against a symmetric triangular carrier,
// normalised by the sampled DC-bus voltage, and drives the leg through the
// dead-time FSM with pwm_en / fault blanking.
// Ports:
//   clk_20M, reset_n : 20 MHz clock, synchronous active-low reset
//   pwm_en           : enable; low forces both gates off
//   ref_in           : signed target leg voltage (same units as udc_in)
//   udc_in           : unsigned DC-bus voltage
//   fault_n          : asynchronous active-low fault, synchronised here
//   fault_clr        : trip clear pulse (latching build only)
//   gate_hi, gate_lo : upper / lower gate drives
//   carrier_sync     : high while carrier count = 0 (valley)
//   carrier_cnt      : current carrier count
//   tripped          : fault blanking active
// Build option: define SPWM_FAULT_LATCH_EN to latch faults until fault_clr.
// Timing: ref_in/udc_in are sampled on the valley edge and held for the
// whole carrier period; carrier_sync marks the cycle in which sampling
// happens at its closing edge.
module spwm_modulator
  import spwm_pkg::*;
#(
  parameter int CARRIER_PEAK = 1000,
  parameter int DEADTIME     = 40
) (
  input  logic                    clk_20M,
  input  logic                    reset_n,
  input  logic                    pwm_en,
  input  logic signed [15:0]      ref_in,
  input  logic        [15:0]      udc_in,
  input  logic                    fault_n,
  input  logic                    fault_clr,
  output logic                    gate_hi,
  output logic                    gate_lo,
  output logic                    carrier_sync,
  output logic        [CNT_W-1:0] carrier_cnt,
  output logic                    tripped
);

  localparam logic [CNT_W-1:0]         PEAK_C  = CNT_W'(CARRIER_PEAK);
  localparam logic [CNT_W-1:0]         PEAK_M1 = CNT_W'(CARRIER_PEAK - 1);
  localparam logic signed [PROD_W-1:0] PEAK_X  = PROD_W'(CARRIER_PEAK);

  // ---------------- carrier ----------------
  logic [CNT_W-1:0] cnt_q;
  logic             dir_up;

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      dir_up <= 1'b1;
    end else if (dir_up) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == PEAK_M1) dir_up <= 1'b0;
    end else begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) dir_up <= 1'b1;
    end
  end

  // Gated by reset_n so the pulse is 0 while in reset and appears on the
  // first running cycle.
  assign carrier_sync = reset_n & (cnt_q == '0);
  assign carrier_cnt  = cnt_q;

  // ---------------- reference sampling ----------------
  logic signed [15:0] ref_l;
  logic        [15:0] udc_l;

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      ref_l <= '0;
      udc_l <= '0;
    end else if (cnt_q == '0) begin
      ref_l <= ref_in;
      udc_l <= udc_in;
    end
  end

  // ---------------- comparator ----------------
  // Desire HIGH iff ref/(udc/2) > c_s/PEAK, cross-multiplied to stay in
  // integers: 2*ref*PEAK > (2*count - PEAK)*udc.
  logic signed [PROD_W-1:0] ref_x;
  logic signed [PROD_W-1:0] udc_x;
  logic signed [PROD_W-1:0] two_ref;
  logic signed [PROD_W-1:0] cs_x;
  logic signed [PROD_W-1:0] lhs;
  logic signed [PROD_W-1:0] rhs;
  logic                     desire_c;
  logic                     desire_q;

  always_comb begin
    ref_x   = {{(PROD_W-16){ref_l[15]}}, ref_l};
    udc_x   = {{(PROD_W-16){1'b0}}, udc_l};
    two_ref = ref_x + ref_x;
    cs_x    = {{(PROD_W-CNT_W-1){1'b0}}, cnt_q, 1'b0} - PEAK_X;
    lhs     = two_ref * PEAK_X;
    rhs     = cs_x * udc_x;
    desire_c = 1'b0;
    if (udc_l == '0) begin
      desire_c = 1'b0;
    end else if (two_ref >= udc_x) begin
      desire_c = 1'b1;
    end else if (-two_ref >= udc_x) begin
      desire_c = 1'b0;
    end else begin
      desire_c = (lhs > rhs);
    end
  end

  always_ff @(posedge clk_20M) begin
    if (!reset_n) desire_q <= 1'b0;
    else          desire_q <= desire_c;
  end

  // ---------------- fault path ----------------
  // Synchroniser idles high so a reset does not look like a fault.
  logic fault_s1;
  logic fault_s2;

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      fault_s1 <= 1'b1;
      fault_s2 <= 1'b1;
    end else begin
      fault_s1 <= fault_n;
      fault_s2 <= fault_s1;
    end
  end

`ifdef SPWM_FAULT_LATCH_EN
  logic trip_q;

  // Set has priority, so a clear while the fault is still present is ignored.
  always_ff @(posedge clk_20M) begin
    if (!reset_n)       trip_q <= 1'b0;
    else if (!fault_s2) trip_q <= 1'b1;
    else if (fault_clr) trip_q <= 1'b0;
  end

  assign tripped = trip_q | ~fault_s2;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign tripped = ~fault_s2;
`endif

  // ---------------- leg FSM ----------------
  logic       blank;
  leg_state_t leg_state;

  assign blank = ~pwm_en | tripped;

  spwm_deadtime #(
    .DEADTIME(DEADTIME)
  ) u_deadtime (
    .clk_20M(clk_20M),
    .reset_n(reset_n),
    .desire (desire_q),
    .blank  (blank),
    .gate_hi(gate_hi),
    .gate_lo(gate_lo),
    .state  (leg_state)
  );

  a_gates_follow_state: assert property (@(posedge clk_20M)
    (gate_hi == (leg_state == ST_UPPER)) && (gate_lo == (leg_state == ST_LOWER)));

  a_no_shoot_through: assert property (@(posedge clk_20M) !(gate_hi && gate_lo));

endmodule
